// File: rtl/window_serializer.sv
// Window serializer: round-robin arbiter over LEVELS detection-window inputs
// that streams the chosen window out as WORD_WIDTH-bit beats, LSB word first.
//
// Ports:
//   clk              system clock
//   rst              synchronous, active-high reset
//   detection_window level i window at [i*WINDOW_WIDTH +: WINDOW_WIDTH]
//   window_valid     per-level window valid
//   window_ready     per-level accept, one-hot or zero, only while idle
//   out_data         current beat
//   out_level        pyramid level of the window being sent
//   out_last         high on the final beat of a window
//   out_valid        beat valid
//   out_ready        downstream accepts the beat
//   busy             high while a window is being sent
module window_serializer #(
  parameter int unsigned WINDOW_WIDTH = 1152,
  parameter int unsigned LEVELS       = 15,
  parameter int unsigned WORD_WIDTH   = 32,
  parameter int unsigned LEVEL_BITS   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WINDOW_WIDTH*LEVELS-1:0] detection_window,
  input  logic [LEVELS-1:0]              window_valid,
  output logic [LEVELS-1:0]              window_ready,
  output logic [WORD_WIDTH-1:0]          out_data,
  output logic [LEVEL_BITS-1:0]          out_level,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy
);

  localparam int unsigned BEATS = WINDOW_WIDTH / WORD_WIDTH;
  localparam int unsigned CntW  = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CntW-1:0]       LastBeat  = CntW'(BEATS - 1);
  localparam logic [LEVEL_BITS-1:0] LastLevel = LEVEL_BITS'(LEVELS - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                  state_q, state_d;
  logic [LEVEL_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [WINDOW_WIDTH-1:0] shift_q, shift_d;
  logic [LEVEL_BITS-1:0]   level_q, level_d;

  logic                    hi_vld, lo_vld, grant_vld;
  logic [LEVEL_BITS-1:0]   hi_idx, lo_idx, grant_idx;
  logic [WINDOW_WIDTH-1:0] sel_window;

  // Round-robin grant: lowest valid index at or above rr_ptr wins; if none,
  // fall back to the lowest valid index below rr_ptr (the wrap-around).
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = 0; i < int'(LEVELS); i++) begin
      if (window_valid[i]) begin
        if (LEVEL_BITS'(i) >= rr_ptr_q) begin
          if (!hi_vld) begin
            hi_vld = 1'b1;
            hi_idx = LEVEL_BITS'(i);
          end
        end else if (!lo_vld) begin
          lo_vld = 1'b1;
          lo_idx = LEVEL_BITS'(i);
        end
      end
    end
    grant_vld = hi_vld | lo_vld;
    grant_idx = hi_vld ? hi_idx : lo_idx;
  end

  // Decode the grant into the ready vector and the captured window slice.
  always_comb begin
    window_ready = '0;
    sel_window   = '0;
    for (int i = 0; i < int'(LEVELS); i++) begin
      if (LEVEL_BITS'(i) == grant_idx) begin
        sel_window      = detection_window[i*WINDOW_WIDTH +: WINDOW_WIDTH];
        // Ready is withheld during reset so no window is consumed and lost.
        window_ready[i] = (state_q == StIdle) && grant_vld && !rst;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    shift_d    = shift_q;
    level_d    = level_q;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          shift_d    = sel_window;
          level_d    = grant_idx;
          beat_cnt_d = '0;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (out_ready) begin
          shift_d    = shift_q >> WORD_WIDTH;
          beat_cnt_d = beat_cnt_q + CntW'(1);
          if (beat_cnt_q == LastBeat) begin
            beat_cnt_d = '0;
            state_d    = StIdle;
            // Just-served level gets lowest priority on the next grant.
            rr_ptr_d   = (level_q == LastLevel) ? '0 : level_q + LEVEL_BITS'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      shift_q    <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      shift_q    <= shift_d;
      level_q    <= level_d;
    end
  end

  // The shift register drains to zero, so out_data reads zero whenever idle.
  assign out_valid = (state_q == StSend);
  assign busy      = (state_q == StSend);
  assign out_last  = (state_q == StSend) && (beat_cnt_q == LastBeat);
  assign out_data  = shift_q[WORD_WIDTH-1:0];
  assign out_level = level_q;

endmodule

// File: tb/tb_window_serializer.sv
// Directed bench for window_serializer with LEVELS=3, 64-bit windows, 16-bit
// beats. A reference arbiter model pushes expected beats into a scoreboard on
// each input handshake; beats are compared against the front every SEND cycle.
module tb_window_serializer;

  localparam int unsigned WW = 64;
  localparam int unsigned LV = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned LB = 2;
  localparam int unsigned NB = WW / DW;

  logic              clk = 1'b0;
  logic              rst;
  logic [WW*LV-1:0]  detection_window;
  logic [LV-1:0]     window_valid;
  logic [LV-1:0]     window_ready;
  logic [DW-1:0]     out_data;
  logic [LB-1:0]     out_level;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  logic [WW-1:0] win [LV];
  assign detection_window = {win[2], win[1], win[0]};

  window_serializer #(
    .WINDOW_WIDTH (WW),
    .LEVELS       (LV),
    .WORD_WIDTH   (DW),
    .LEVEL_BITS   (LB)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .detection_window (detection_window),
    .window_valid     (window_valid),
    .window_ready     (window_ready),
    .out_data         (out_data),
    .out_level        (out_level),
    .out_last         (out_last),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [LB-1:0] level;
    logic          last;
  } beat_t;

  beat_t sb[$];
  int    hs_cyc[$];
  int    hs_lvl[$];

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cyc    = 0;
  int exp_ptr = 0;
  bit m_busy = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare at the falling edge, advance the model, then return
  // 1 time unit after the rising edge so the caller can drive new inputs.
  task automatic step();
    bit    found;
    int    g;
    beat_t b;
    @(negedge clk);
    if (rst) begin
      chk("ready_in_rst", 64'(window_ready), 64'd0);
    end else begin
      found = 1'b0;
      g     = 0;
      if (!m_busy) begin
        for (int k = 0; k < int'(LV); k++) begin
          int idx;
          idx = (exp_ptr + k) % int'(LV);
          if (!found && window_valid[idx]) begin
            found = 1'b1;
            g     = idx;
          end
        end
      end
      chk("window_ready", 64'(window_ready), found ? 64'(1 << g) : 64'd0);
      chk("busy", 64'(busy), 64'(m_busy));
      chk("out_valid", 64'(out_valid), 64'(m_busy));
      if (m_busy) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          chk("out_data", 64'(out_data), 64'(sb[0].data));
          chk("out_level", 64'(out_level), 64'(sb[0].level));
          chk("out_last", 64'(out_last), 64'(sb[0].last));
          if (out_ready) begin
            b = sb.pop_front();
            if (b.last) begin
              m_busy  = 1'b0;
              exp_ptr = (int'(b.level) == int'(LV) - 1) ? 0 : int'(b.level) + 1;
            end
          end
        end
      end else begin
        chk("idle_data", 64'(out_data), 64'd0);
        chk("idle_last", 64'(out_last), 64'd0);
      end
      if (found) begin
        for (int k = 0; k < int'(NB); k++) begin
          b.data  = win[g][k*DW +: DW];
          b.level = LB'(g);
          b.last  = (k == int'(NB) - 1);
          sb.push_back(b);
        end
        m_busy = 1'b1;
        hs_cyc.push_back(cyc);
        hs_lvl.push_back(g);
      end
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      sb.delete();
      m_busy  = 1'b0;
      exp_ptr = 0;
    end
    #1;
  endtask

  task automatic wait_grants(input int n, input int budget);
    int start;
    int t;
    start = hs_lvl.size();
    t = 0;
    while (hs_lvl.size() < start + n && t < budget) begin
      step();
      t++;
    end
    chk("grant_timeout", 64'(hs_lvl.size() >= start + n), 64'd1);
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while (m_busy && t < budget) begin
      step();
      t++;
    end
    chk("drain_timeout", 64'(m_busy), 64'd0);
    step();
  endtask

  initial begin
    win[0] = 64'hAAAA_9999_8888_7777;
    win[1] = 64'h4444_3333_2222_1111;
    win[2] = 64'hDDDD_CCCC_BBBB_EEEE;
    rst = 1'b1;
    window_valid = '0;
    out_ready = 1'b1;

    // Reset then idle.
    step();
    step();
    rst = 1'b0;
    step();
    step();

    // Single window from level 1.
    window_valid = 3'b010;
    wait_grants(1, 10);
    window_valid = 3'b000;
    chk("single_lvl", 64'(hs_lvl[hs_lvl.size()-1]), 64'd1);
    drain(20);

    // Pointer is now 2; only level 0 valid -> wraps to level 0.
    window_valid = 3'b001;
    wait_grants(1, 10);
    window_valid = 3'b000;
    chk("wrap_lvl", 64'(hs_lvl[hs_lvl.size()-1]), 64'd0);
    drain(20);

    // Pointer is now 1; level 1 absent, so level 2 beats level 0.
    window_valid = 3'b101;
    wait_grants(1, 10);
    window_valid = 3'b000;
    chk("skip_lvl", 64'(hs_lvl[hs_lvl.size()-1]), 64'd2);
    drain(20);

    // Backpressure during beat 2.
    window_valid = 3'b010;
    wait_grants(1, 10);
    window_valid = 3'b000;
    step();
    step();
    out_ready = 1'b0;
    step();
    step();
    step();
    chk("stall_data", 64'(out_data), 64'h3333);
    chk("stall_last", 64'(out_last), 64'd0);
    out_ready = 1'b1;
    drain(20);

    // Reset after beat 1 of a level-0 window is accepted.
    window_valid = 3'b001;
    wait_grants(1, 10);
    window_valid = 3'b000;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    window_valid = 3'b100;
    wait_grants(1, 10);
    window_valid = 3'b000;
    chk("post_rst_lvl", 64'(hs_lvl[hs_lvl.size()-1]), 64'd2);
    drain(20);

    // Round robin with all levels valid, pointer back at 0.
    begin
      int base;
      int exp_lv [4];
      exp_lv = '{0, 1, 2, 0};
      base = hs_lvl.size();
      window_valid = 3'b111;
      wait_grants(4, 40);
      window_valid = 3'b000;
      for (int i = 0; i < 4; i++) begin
        if (base + i < hs_lvl.size()) begin
          chk("rr_lvl", 64'(hs_lvl[base+i]), 64'(exp_lv[i]));
          if (i > 0) chk("rr_period", 64'(hs_cyc[base+i] - hs_cyc[base+i-1]), 64'd5);
        end
      end
      drain(20);
    end

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
